// File: rtl/axis_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_checker
//  Description : AXI4-Stream sink that checks benchmark Ethernet frames beat
//                by beat (two header words, incrementing payload pattern,
//                full strobes, TLAST placement). It reports per-frame
//                pulses, saturating good/bad counters and the first error
//                code of the most recent bad frame.
//                Optional macro AXIS_CHECKER_BACKPRESSURE_EN adds LFSR-driven
//                random backpressure on TREADY.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_checker #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 64,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          PAYLOAD_WORDS        = 32,
    parameter logic [63:0] HEADER_WORD_0        = 64'hEFBEFECAFECAFECA,
    parameter logic [63:0] HEADER_WORD_1        = 64'h00000008EFBEEFBE
) (
    input  logic                            ACLK,
    input  logic                            RESET,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]  S_AXIS_TDATA,
    input  logic [7:0]                      S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] S_AXIS_TUSER,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic                            clear_counters,
    output logic                            pkt_ok,
    output logic                            pkt_err,
    output logic [31:0]                     good_count,
    output logic [31:0]                     bad_count,
    output logic [2:0]                      err_code
);

    // Index of the final payload beat; 8-bit so PAYLOAD_WORDS=256 maps to 255.
    localparam logic [7:0] c_LAST_IDX = 8'(PAYLOAD_WORDS - 1);

    localparam logic [2:0] c_ERR_NONE  = 3'd0;
    localparam logic [2:0] c_ERR_HDR0  = 3'd1;
    localparam logic [2:0] c_ERR_HDR1  = 3'd2;
    localparam logic [2:0] c_ERR_PAY   = 3'd3;
    localparam logic [2:0] c_ERR_EARLY = 3'd4;
    localparam logic [2:0] c_ERR_MISS  = 3'd5;
    localparam logic [2:0] c_ERR_STRB  = 3'd6;

    typedef enum logic [1:0] {
        ST_HDR0    = 2'd0,
        ST_HDR1    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_flag;
    logic [2:0]  r_first;
    logic        r_ready_en;
    logic        r_pkt_ok;
    logic        r_pkt_err;
    logic [31:0] r_good_count;
    logic [31:0] r_bad_count;
    logic [2:0]  r_err_code;

    logic        w_accept;
    logic        w_strb_err;
    logic        w_checked;
    logic [2:0]  w_data_code;
    logic        w_early;
    logic        w_missing;
    logic        w_done;
    logic [2:0]  w_beat_code;
    logic [2:0]  w_frame_code;
    logic        w_frame_bad;
    logic        w_unused_tuser;

    // TUSER carries nothing this checker cares about.
    assign w_unused_tuser = ^S_AXIS_TUSER;

    assign w_accept   = S_AXIS_TVALID & S_AXIS_TREADY;
    assign w_strb_err = (S_AXIS_TSTRB != 8'hFF);
    assign w_checked  = (r_state != ST_DRAIN);

    // Decode the current beat: data code, framing errors, next state, completion.
    always_comb begin
        w_data_code = c_ERR_NONE;
        w_early     = 1'b0;
        w_missing   = 1'b0;
        w_done      = 1'b0;
        w_next      = r_state;
        case (r_state)
            ST_HDR0: begin
                if (S_AXIS_TDATA != HEADER_WORD_0) w_data_code = c_ERR_HDR0;
                if (S_AXIS_TLAST) begin
                    w_early = 1'b1;
                    w_done  = 1'b1;
                    w_next  = ST_HDR0;
                end else begin
                    w_next  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (S_AXIS_TDATA != HEADER_WORD_1) w_data_code = c_ERR_HDR1;
                if (S_AXIS_TLAST) begin
                    w_early = 1'b1;
                    w_done  = 1'b1;
                    w_next  = ST_HDR0;
                end else begin
                    w_next  = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (S_AXIS_TDATA != {8{r_cnt}}) w_data_code = c_ERR_PAY;
                if (r_cnt == c_LAST_IDX) begin
                    if (S_AXIS_TLAST) begin
                        w_done = 1'b1;
                        w_next = ST_HDR0;
                    end else begin
                        w_missing = 1'b1;
                        w_next    = ST_DRAIN;
                    end
                end else if (S_AXIS_TLAST) begin
                    w_early = 1'b1;
                    w_done  = 1'b1;
                    w_next  = ST_HDR0;
                end
            end
            default: begin
                if (S_AXIS_TLAST) begin
                    w_done = 1'b1;
                    w_next = ST_HDR0;
                end
            end
        endcase
    end

    // Beat code priority: a strobe error displaces data mismatches, otherwise
    // the lowest-numbered error wins. Drain beats are never checked.
    always_comb begin
        w_beat_code = c_ERR_NONE;
        if (w_checked && w_strb_err) begin
            if (w_early)        w_beat_code = c_ERR_EARLY;
            else if (w_missing) w_beat_code = c_ERR_MISS;
            else                w_beat_code = c_ERR_STRB;
        end else if (w_data_code != c_ERR_NONE) begin
            w_beat_code = w_data_code;
        end else if (w_early) begin
            w_beat_code = c_ERR_EARLY;
        end else if (w_missing) begin
            w_beat_code = c_ERR_MISS;
        end
    end

    assign w_frame_code = r_flag ? r_first : w_beat_code;
    assign w_frame_bad  = r_flag | (w_beat_code != c_ERR_NONE);

    // Framing state machine plus per-frame first-error tracking.
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_HDR0;
            r_cnt   <= 8'd0;
            r_flag  <= 1'b0;
            r_first <= c_ERR_NONE;
        end else if (w_accept) begin
            r_state <= w_next;
            if (r_state == ST_PAYLOAD && w_next == ST_PAYLOAD) r_cnt <= r_cnt + 8'd1;
            else                                              r_cnt <= 8'd0;
            if (w_done) begin
                r_flag  <= 1'b0;
                r_first <= c_ERR_NONE;
            end else if (!r_flag && w_beat_code != c_ERR_NONE) begin
                r_flag  <= 1'b1;
                r_first <= w_beat_code;
            end
        end
    end

    // Completion pulses, saturating counters and err_code; clear beats a completion.
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            r_pkt_ok     <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_good_count <= 32'd0;
            r_bad_count  <= 32'd0;
            r_err_code   <= c_ERR_NONE;
        end else begin
            r_pkt_ok  <= w_accept & w_done & ~w_frame_bad;
            r_pkt_err <= w_accept & w_done & w_frame_bad;
            if (clear_counters) begin
                r_good_count <= 32'd0;
                r_bad_count  <= 32'd0;
                r_err_code   <= c_ERR_NONE;
            end else if (w_accept && w_done) begin
                if (w_frame_bad) begin
                    if (r_bad_count != 32'hFFFF_FFFF) r_bad_count <= r_bad_count + 32'd1;
                    r_err_code <= w_frame_code;
                end else if (r_good_count != 32'hFFFF_FFFF) begin
                    r_good_count <= r_good_count + 32'd1;
                end
            end
        end
    end

    // TREADY is held low during reset and enabled on the first edge after it.
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) r_ready_en <= 1'b0;
        else       r_ready_en <= 1'b1;
    end

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Free-running LFSR supplying pseudo-random backpressure.
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) r_lfsr <= c_LFSR_SEED;
        else       r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end

    assign S_AXIS_TREADY = r_ready_en & (r_lfsr[1:0] != 2'b00);
`else
    assign S_AXIS_TREADY = r_ready_en;
`endif

    assign pkt_ok     = r_pkt_ok;
    assign pkt_err    = r_pkt_err;
    assign good_count = r_good_count;
    assign bad_count  = r_bad_count;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_frame_checker
//  Description : Self-checking bench for axis_frame_checker. Frames are built
//                as beat queues, optionally corrupted at random, and the
//                expected outcome is computed from the beat positions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_checker;

    localparam int          P  = 32;
    localparam logic [63:0] H0 = 64'hEFBEFECAFECAFECA;
    localparam logic [63:0] H1 = 64'h00000008EFBEEFBE;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  tdata = '0;
    logic [7:0]   tstrb = '0;
    logic [127:0] tuser = '0;
    logic         tlast = 1'b0;
    logic         tvalid = 1'b0;
    logic         tready;
    logic         clear = 1'b0;
    logic         pkt_ok;
    logic         pkt_err;
    logic [31:0]  good_count;
    logic [31:0]  bad_count;
    logic [2:0]   err_code;

    int errors = 0;
    int checks = 0;
    int n_ok   = 0;
    int n_err  = 0;

    logic [31:0] exp_good = 0;
    logic [31:0] exp_bad  = 0;
    logic [2:0]  exp_code = 0;
    logic        e_ok = 0;
    logic        e_err = 0;

    logic [63:0] q_data[$];
    logic [7:0]  q_strb[$];
    logic        q_last[$];

    axis_frame_checker #(
        .C_S_AXIS_DATA_WIDTH (64),
        .C_S_AXIS_TUSER_WIDTH(128),
        .PAYLOAD_WORDS       (P),
        .HEADER_WORD_0       (H0),
        .HEADER_WORD_1       (H1)
    ) dut (
        .ACLK          (clk),
        .RESET         (rst),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TUSER  (tuser),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .clear_counters(clear),
        .pkt_ok        (pkt_ok),
        .pkt_err       (pkt_err),
        .good_count    (good_count),
        .bad_count     (bad_count),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    // Pulse tally: the value seen at a rising edge is the previous cycle's output.
    always @(posedge clk) begin
        if (pkt_ok === 1'b1)  n_ok  <= n_ok + 1;
        if (pkt_err === 1'b1) n_err <= n_err + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // A correct frame: two header words then payload bytes 0,1,2,...
    task automatic build_good();
        logic [7:0] b;
        q_data = {}; q_strb = {}; q_last = {};
        q_data.push_back(H0); q_strb.push_back(8'hFF); q_last.push_back(1'b0);
        q_data.push_back(H1); q_strb.push_back(8'hFF); q_last.push_back(1'b0);
        for (int i = 0; i < P; i++) begin
            b = i[7:0];
            q_data.push_back({8{b}}); q_strb.push_back(8'hFF); q_last.push_back(i == P - 1);
        end
    endtask

    // Outcome of the queued frame: {bad, first code}. Position 0/1 are the
    // headers, 2..P+1 the payload, anything after is drained unchecked.
    function automatic logic [3:0] model_frame();
        logic [2:0]  first;
        logic [6:1]  s;
        logic [63:0] want;
        logic [7:0]  ib;
        logic [2:0]  c;
        first = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (i <= P + 1) begin
                ib   = 8'(i - 2);
                want = (i == 0) ? H0 : (i == 1) ? H1 : {8{ib}};
                s    = '0;
                s[1] = (i == 0) && (q_data[i] != want);
                s[2] = (i == 1) && (q_data[i] != want);
                s[3] = (i >= 2) && (q_data[i] != want);
                s[4] = q_last[i] && (i < P + 1);
                s[5] = !q_last[i] && (i == P + 1);
                s[6] = (q_strb[i] != 8'hFF);
                if (s[6]) s[3:1] = '0;
                c = 0;
                for (int k = 6; k >= 1; k--) if (s[k]) c = 3'(k);
                if (first == 0) first = c;
            end
        end
        return {first != 0, first};
    endfunction

    // Update the expected pulses/counters for one completed frame.
    task automatic expect_frame(input logic clr);
        logic [3:0] m;
        m = model_frame();
        e_ok  = !m[3];
        e_err = m[3];
        if (clr) begin
            exp_good = 0; exp_bad = 0; exp_code = 0;
        end else if (m[3]) begin
            exp_bad  = exp_bad + 1;
            exp_code = m[2:0];
        end else begin
            exp_good = exp_good + 1;
        end
    endtask

    // Drive the queued beats, each held until accepted; returns on the falling
    // edge after the last acceptance.
    task automatic send_frame(input logic clr_last);
        int   n;
        logic acc;
        n = q_data.size();
        for (int b = 0; b < n; b++) begin
            tdata  = q_data[b];
            tstrb  = q_strb[b];
            tlast  = q_last[b];
            tuser  = {$urandom, $urandom, $urandom, $urandom};
            tvalid = 1'b1;
            clear  = clr_last && (b == n - 1);
            acc    = 1'b0;
            for (int w = 0; w < 64 && !acc; w++) begin
                acc = tready;
                @(posedge clk);
                @(negedge clk);
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL handshake_timeout: beat %0d TREADY=%b required 1", b, tready);
                break;
            end
        end
        tvalid = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({tready, pkt_ok, pkt_err, good_count, bad_count, err_code} !== '0) begin
            errors++;
            $display("FAIL reset_values: tready=%b ok=%b err=%b good=%0d bad=%0d code=%0d required all 0",
                     tready, pkt_ok, pkt_err, good_count, bad_count, err_code);
        end
        rst = 1'b0;
        @(negedge clk);
`ifndef AXIS_CHECKER_BACKPRESSURE_EN
        checks++;
        if (tready !== 1'b1) begin
            errors++; $display("FAIL tready_rise: tready=%b required 1", tready);
        end
`endif
    endtask

    task automatic test_good_frame();
        int ok0;
        ok0 = n_ok;
        build_good();
        send_frame(1'b0);
        expect_frame(1'b0);
        checks++;
        if (pkt_ok !== 1'b1 || pkt_err !== 1'b0) begin
            errors++; $display("FAIL good_pulse: ok/err=%b%b required 10", pkt_ok, pkt_err);
        end
        checks++;
        if (good_count !== 32'd1 || bad_count !== 32'd0 || err_code !== 3'd0) begin
            errors++; $display("FAIL good_counts: good=%0d bad=%0d code=%0d required 1 0 0", good_count, bad_count, err_code);
        end
        idle(2);
        checks++;
        if (pkt_ok !== 1'b0 || n_ok - ok0 != 1) begin
            errors++; $display("FAIL good_single_pulse: ok=%b pulses=%0d required 0 and 1", pkt_ok, n_ok - ok0);
        end
    endtask

    task automatic test_payload_error();
        build_good();
        q_data[2 + 5] = 64'h0505050505050504;
        send_frame(1'b0);
        expect_frame(1'b0);
        checks++;
        if (pkt_err !== 1'b1 || pkt_ok !== 1'b0 || bad_count !== 32'd1 || err_code !== 3'd3) begin
            errors++; $display("FAIL payload_err: ok/err=%b%b bad=%0d code=%0d required 01 1 3", pkt_ok, pkt_err, bad_count, err_code);
        end
        build_good();
        send_frame(1'b0);
        expect_frame(1'b0);
        checks++;
        if (pkt_ok !== 1'b1 || good_count !== exp_good || err_code !== 3'd3) begin
            errors++; $display("FAIL payload_recover: ok=%b good=%0d code=%0d required 1 %0d 3", pkt_ok, good_count, err_code, exp_good);
        end
    endtask

    task automatic test_early_tlast();
        build_good();
        while (q_data.size() > 2 + 16 + 1) begin
            void'(q_data.pop_back()); void'(q_strb.pop_back()); void'(q_last.pop_back());
        end
        q_last[2 + 16] = 1'b1;
        send_frame(1'b0);
        expect_frame(1'b0);
        checks++;
        if (pkt_err !== 1'b1 || err_code !== 3'd4 || bad_count !== exp_bad) begin
            errors++; $display("FAIL early_tlast: err=%b code=%0d bad=%0d required 1 4 %0d", pkt_err, err_code, bad_count, exp_bad);
        end
        build_good();
        send_frame(1'b0);
        expect_frame(1'b0);
        checks++;
        if (pkt_ok !== 1'b1 || good_count !== exp_good) begin
            errors++; $display("FAIL early_recover: ok=%b good=%0d required 1 %0d", pkt_ok, good_count, exp_good);
        end
    endtask

    task automatic test_missing_tlast();
        int err0;
        build_good();
        q_last[P + 1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            q_data.push_back(64'($urandom)); q_strb.push_back(8'hFF); q_last.push_back(k == 2);
        end
        err0 = n_err;
        send_frame(1'b0);
        expect_frame(1'b0);
        checks++;
        if (pkt_err !== 1'b1 || err_code !== 3'd5 || bad_count !== exp_bad) begin
            errors++; $display("FAIL missing_tlast: err=%b code=%0d bad=%0d required 1 5 %0d", pkt_err, err_code, bad_count, exp_bad);
        end
        idle(2);
        checks++;
        if (n_err - err0 != 1) begin
            errors++; $display("FAIL missing_single_pulse: pulses=%0d required 1", n_err - err0);
        end
    endtask

    task automatic test_strb_priority();
        build_good();
        q_strb[1] = 8'h0F;
        q_data[1] = q_data[1] ^ 64'h1;
        send_frame(1'b0);
        expect_frame(1'b0);
        checks++;
        if (pkt_err !== 1'b1 || err_code !== 3'd6) begin
            errors++; $display("FAIL strb_priority: err=%b code=%0d required 1 6", pkt_err, err_code);
        end
    endtask

    task automatic test_random();
        int kind, j, len, k;
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 4);
            build_good();
            case (kind)
                1: begin
                    j = $urandom_range(0, P + 1);
                    q_data[j] = q_data[j] ^ (64'd1 << $urandom_range(0, 63));
                end
                2: begin
                    j = $urandom_range(0, P + 1);
                    q_strb[j] = 8'($urandom_range(0, 254));
                end
                3: begin
                    len = $urandom_range(1, P + 1);
                    while (q_data.size() > len) begin
                        void'(q_data.pop_back()); void'(q_strb.pop_back()); void'(q_last.pop_back());
                    end
                    q_last[len - 1] = 1'b1;
                end
                4: begin
                    q_last[P + 1] = 1'b0;
                    k = $urandom_range(1, 3);
                    for (int e = 0; e < k; e++) begin
                        q_data.push_back(64'($urandom)); q_strb.push_back(8'($urandom)); q_last.push_back(e == k - 1);
                    end
                end
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, q_data.size() - 1);
                q_data[j] = q_data[j] ^ (64'd1 << $urandom_range(0, 63));
            end
            send_frame(1'b0);
            expect_frame(1'b0);
            checks++;
            if (pkt_ok !== e_ok || pkt_err !== e_err || good_count !== exp_good || bad_count !== exp_bad || err_code !== exp_code) begin
                errors++;
                $display("FAIL random_frame %0d kind %0d: ok/err=%b%b good=%0d bad=%0d code=%0d required %b%b %0d %0d %0d",
                         f, kind, pkt_ok, pkt_err, good_count, bad_count, err_code, e_ok, e_err, exp_good, exp_bad, exp_code);
            end
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_good = 0; exp_bad = 0; exp_code = 0;
        checks++;
        if (good_count !== 32'd0 || bad_count !== 32'd0 || err_code !== 3'd0) begin
            errors++; $display("FAIL clear_idle: good=%0d bad=%0d code=%0d required 0 0 0", good_count, bad_count, err_code);
        end
        for (int f = 0; f < 100; f++) begin
            build_good();
            send_frame(1'b0);
            expect_frame(1'b0);
            checks++;
            if (pkt_ok !== 1'b1 || good_count !== exp_good) begin
                errors++; $display("FAIL b2b_frame %0d: ok=%b good=%0d required 1 %0d", f, pkt_ok, good_count, exp_good);
            end
        end
        checks++;
        if (good_count !== 32'd100 || bad_count !== 32'd0) begin
            errors++; $display("FAIL b2b_total: good=%0d bad=%0d required 100 0", good_count, bad_count);
        end
        build_good();
        send_frame(1'b1);
        expect_frame(1'b1);
        checks++;
        if (pkt_ok !== 1'b1 || good_count !== 32'd0 || bad_count !== 32'd0 || err_code !== 3'd0) begin
            errors++; $display("FAIL clear_on_completion: ok=%b good=%0d bad=%0d code=%0d required 1 0 0 0", pkt_ok, good_count, bad_count, err_code);
        end
    endtask

    task automatic test_reset_mid_frame();
        build_good();
        while (q_data.size() > 10) begin
            void'(q_data.pop_back()); void'(q_strb.pop_back()); void'(q_last.pop_back());
        end
        send_frame(1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (tready !== 1'b0 || good_count !== 32'd0 || bad_count !== 32'd0 || pkt_ok !== 1'b0 || pkt_err !== 1'b0) begin
            errors++; $display("FAIL reset_async: tready=%b good=%0d bad=%0d ok/err=%b%b required 0 0 0 00", tready, good_count, bad_count, pkt_ok, pkt_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_good = 0; exp_bad = 0; exp_code = 0;
        build_good();
        send_frame(1'b0);
        expect_frame(1'b0);
        checks++;
        if (pkt_ok !== 1'b1 || good_count !== 32'd1 || bad_count !== 32'd0) begin
            errors++; $display("FAIL reset_recover: ok=%b good=%0d bad=%0d required 1 1 0", pkt_ok, good_count, bad_count);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_payload_error();
        test_early_tlast();
        test_missing_tlast();
        test_strb_priority();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
